// File: rtl/bru_pkg.sv
// bru_pkg: shared types, opcodes and gshare indexing for the branch-prediction loop
package bru_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam int BRU_PC_W  = 32;
    localparam int BRU_GHR_W = 8;

    typedef struct packed {
        logic [BRU_PC_W-1:0]  pc;
        logic                 taken;
        logic [BRU_PC_W-1:0]  target;
        logic [BRU_GHR_W-1:0] ghr_snap;
    } bru_entry_t;

    // Word-aligned PC bits folded with global history; fetch and resolve must agree.
    function automatic logic [BRU_GHR_W-1:0] gshare_index(
        input logic [BRU_PC_W-1:0]  pc,
        input logic [BRU_GHR_W-1:0] ghr
    );
        return pc[BRU_GHR_W+1:2] ^ ghr;
    endfunction

endpackage

// File: rtl/bru_queue.sv
// bru_queue: circular FIFO of in-flight predictions with whole-queue clear
module bru_queue
    import bru_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && count != '0;
    assign rdata   = mem[rptr];

    // Entry storage needs no reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally at the power-of-two depth; clear drops everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks resolved control flow against recorded predictions, flushes and trains
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GHR_W = BRU_GHR_W,
    parameter int PC_W  = BRU_PC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    input  logic             pred_taken,
    input  logic [PC_W-1:0]  pred_target,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_target,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic [GHR_W-1:0] upd_index,
    output logic             upd_taken,
    output logic [GHR_W-1:0] spec_ghr,
    output logic [15:0]      mispred_cnt,
    output logic             err_underflow
);

    localparam int EW = 2 * PC_W + 1 + GHR_W;
    localparam int CW = $clog2(DEPTH + 1);

    logic [EW-1:0]    head;
    logic [PC_W-1:0]  head_pc, head_target;
    logic             head_taken;
    logic [GHR_W-1:0] head_snap, ghr_next;
    logic [CW-1:0]    count;
    logic             full, resolve, mis, push;

    assign {head_pc, head_taken, head_target, head_snap} = head;
    assign pred_ready = !full;
    assign resolve    = res_valid && count != '0;
    assign mis        = resolve && (res_taken != head_taken || (res_taken && res_target != head_target));
    assign push       = pred_valid && pred_ready && !mis;

    bru_queue #(.DEPTH(DEPTH), .W(EW)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (resolve && !mis),
        .clear (mis),
        .wdata ({pred_pc, pred_taken, pred_target, spec_ghr}),
        .rdata (head),
        .count (count),
        .full  (full)
    );

    // Repair from the mispredicted entry's snapshot beats any same-cycle push.
    always_comb begin
        ghr_next = mis  ? {head_snap[GHR_W-2:0], res_taken}
                 : push ? {spec_ghr[GHR_W-2:0], pred_taken}
                 : spec_ghr;
    end

    // Registered resolve results: one-cycle pulses, payloads hold between resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_ghr      <= '0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
            upd_valid     <= 1'b0;
            upd_index     <= '0;
            upd_taken     <= 1'b0;
            mispred_cnt   <= '0;
            err_underflow <= 1'b0;
        end else begin
            spec_ghr  <= ghr_next;
            flush     <= mis;
            upd_valid <= resolve;
            if (resolve) begin
                upd_index <= head_pc[GHR_W+1:2] ^ head_snap;
                upd_taken <= res_taken;
            end
            if (mis) begin
                redirect_pc <= res_taken ? res_target : head_pc + PC_W'(4);
                mispred_cnt <= mispred_cnt + 16'd1;
            end
            if (res_valid && count == '0) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scenarios plus randomized run against a queue-based model
module tb_branch_resolve_unit;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
    logic [31:0] pred_pc = '0, pred_target = '0, res_target = '0;
    logic        pred_ready, flush, upd_valid, upd_taken, err_underflow;
    logic [31:0] redirect_pc;
    logic [7:0]  upd_index, spec_ghr;
    logic [15:0] mispred_cnt;

    int passed = 0, total = 0;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .spec_ghr(spec_ghr), .mispred_cnt(mispred_cnt), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        t;
        logic [31:0] tg;
        logic [7:0]  snap;
    } ent_t;

    ent_t        q[$];
    logic [7:0]  m_ghr, m_ui;
    logic        m_flush, m_uv, m_ut, m_err;
    logic [31:0] m_redir;
    logic [15:0] m_cnt;

    task automatic model_reset();
        q.delete();
        m_ghr = '0; m_ui = '0; m_flush = 0; m_uv = 0; m_ut = 0; m_err = 0; m_redir = '0; m_cnt = '0;
    endtask

    task automatic model_edge();
        ent_t h;
        bit mis = 0;
        bit ready = q.size() < 4;
        m_flush = 0;
        m_uv = 0;
        if (res_valid && q.size() == 0) m_err = 1;
        else if (res_valid) begin
            h = q.pop_front();
            mis = (res_taken != h.t) || (res_taken && res_target != h.tg);
            m_uv = 1;
            m_ui = h.pc[9:2] ^ h.snap;
            m_ut = res_taken;
            if (mis) begin
                m_flush = 1;
                m_redir = res_taken ? res_target : h.pc + 32'd4;
                q.delete();
                m_ghr = {h.snap[6:0], res_taken};
                m_cnt++;
            end
        end
        if (pred_valid && ready && !mis) begin
            q.push_back('{pred_pc, pred_taken, pred_target, m_ghr});
            m_ghr = {m_ghr[6:0], pred_taken};
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        pred_valid = 0;
        res_valid = 0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        pred_valid = 1; pred_pc = pc; pred_taken = t; pred_target = tg;
    endtask

    task automatic set_res(input logic t, input logic [31:0] tg);
        res_valid = 1; res_taken = t; res_target = tg;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        #2;
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        #1;
        total++; if (pred_ready !== 1'b1) $display("FAIL rst_ready: got %0h want 1", pred_ready); else passed++;
        total++; if ({flush, upd_valid, upd_taken, err_underflow} !== 4'b0) $display("FAIL rst_flags: got %0h want 0", {flush, upd_valid, upd_taken, err_underflow}); else passed++;
        total++; if ({redirect_pc, upd_index, spec_ghr, mispred_cnt} !== '0) $display("FAIL rst_values: got %0h want 0", {redirect_pc, upd_index, spec_ghr, mispred_cnt}); else passed++;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_correct_taken();
        do_reset();
        set_push(32'h40, 1, 32'h80); step(); idle();
        set_res(1, 32'h80); step(); idle();
        total++; if (flush !== 1'b0) $display("FAIL corr_flush: got %0h want 0", flush); else passed++;
        total++; if ({upd_valid, upd_taken} !== 2'b11) $display("FAIL corr_upd: got %0h want 3", {upd_valid, upd_taken}); else passed++;
        total++; if (upd_index !== 8'h10) $display("FAIL corr_index: got %0h want 10", upd_index); else passed++;
        total++; if ({mispred_cnt, pred_ready} !== 17'h1) $display("FAIL corr_cnt_ready: got %0h want 1", {mispred_cnt, pred_ready}); else passed++;
        step();
        total++; if (upd_valid !== 1'b0) $display("FAIL corr_upd_pulse: got %0h want 0", upd_valid); else passed++;
    endtask

    task automatic test_mispredict_not_taken();
        do_reset();
        set_push(32'h100, 0, 32'h0); step(); idle();
        set_res(1, 32'h200); step(); idle();
        total++; if (flush !== 1'b1) $display("FAIL mnt_flush: got %0h want 1", flush); else passed++;
        total++; if (redirect_pc !== 32'h200) $display("FAIL mnt_redirect: got %0h want 200", redirect_pc); else passed++;
        total++; if (mispred_cnt !== 16'd1) $display("FAIL mnt_cnt: got %0h want 1", mispred_cnt); else passed++;
        step();
        total++; if ({flush, redirect_pc} !== {1'b0, 32'h200}) $display("FAIL mnt_pulse_hold: got %0h want 200", {flush, redirect_pc}); else passed++;
    endtask

    task automatic test_mispredict_taken();
        do_reset();
        set_push(32'h100, 1, 32'h140); step(); idle();
        set_res(0, 32'h0); step(); idle();
        total++; if ({flush, redirect_pc} !== {1'b1, 32'h104}) $display("FAIL mt_redirect: got %0h want 100000104", {flush, redirect_pc}); else passed++;
        total++; if ({upd_valid, upd_taken} !== 2'b10) $display("FAIL mt_upd: got %0h want 2", {upd_valid, upd_taken}); else passed++;
    endtask

    task automatic test_full_and_drop();
        do_reset();
        set_push(32'h200, 1, 32'h1000); step();
        set_push(32'h204, 0, 32'h0);    step();
        set_push(32'h208, 1, 32'h2000); step();
        set_push(32'h20C, 1, 32'h3000); step();
        total++; if ({pred_ready, spec_ghr} !== {1'b0, 8'h0B}) $display("FAIL full_ready: got %0h want b", {pred_ready, spec_ghr}); else passed++;
        set_push(32'h210, 0, 32'h0); step();
        total++; if ({pred_ready, spec_ghr} !== {1'b0, 8'h0B}) $display("FAIL full_ignored: got %0h want b", {pred_ready, spec_ghr}); else passed++;
        set_res(0, 32'h0); step(); idle();
        total++; if ({flush, redirect_pc} !== {1'b1, 32'h204}) $display("FAIL full_mis: got %0h want 100000204", {flush, redirect_pc}); else passed++;
        total++; if ({pred_ready, spec_ghr} !== {1'b1, 8'h00}) $display("FAIL full_clear: got %0h want 100", {pred_ready, spec_ghr}); else passed++;
        set_push(32'h300, 1, 32'h340); step(); idle();
        set_res(1, 32'h999); set_push(32'h400, 1, 32'h440); step(); idle();
        total++; if ({flush, redirect_pc, spec_ghr} !== {1'b1, 32'h999, 8'h01}) $display("FAIL drop_repair: got %0h want 10000099901", {flush, redirect_pc, spec_ghr}); else passed++;
        total++; if (mispred_cnt !== 16'd2) $display("FAIL drop_cnt: got %0h want 2", mispred_cnt); else passed++;
        set_res(1, 32'h440); step(); idle();
        total++; if ({flush, upd_valid, err_underflow} !== 3'b001) $display("FAIL drop_empty: got %0h want 1", {flush, upd_valid, err_underflow}); else passed++;
    endtask

    task automatic test_ghr_index();
        do_reset();
        set_push(32'h20, 1, 32'h60); step();
        set_push(32'h24, 1, 32'h70); step();
        set_push(32'h28, 0, 32'h0);  step(); idle();
        total++; if (spec_ghr !== 8'h06) $display("FAIL ghr_shift: got %0h want 6", spec_ghr); else passed++;
        set_res(1, 32'h60); step();
        total++; if ({flush, upd_valid, upd_index} !== {2'b01, 8'h08}) $display("FAIL ghr_idx0: got %0h want 108", {flush, upd_valid, upd_index}); else passed++;
        set_res(1, 32'h70); set_push(32'h2C, 1, 32'h90); step(); idle();
        total++; if ({flush, upd_valid, upd_index} !== {2'b01, 8'h08}) $display("FAIL b2b_idx1: got %0h want 108", {flush, upd_valid, upd_index}); else passed++;
        total++; if (spec_ghr !== 8'h0D) $display("FAIL b2b_push_wins: got %0h want d", spec_ghr); else passed++;
        set_res(0, 32'h0); step(); idle();
        total++; if ({flush, upd_valid, upd_taken, upd_index} !== {3'b010, 8'h09}) $display("FAIL b2b_idx2: got %0h want 209", {flush, upd_valid, upd_taken, upd_index}); else passed++;
        step();
        total++; if ({upd_valid, upd_index} !== {1'b0, 8'h09}) $display("FAIL b2b_hold: got %0h want 9", {upd_valid, upd_index}); else passed++;
    endtask

    task automatic test_underflow_and_async_reset();
        do_reset();
        set_res(1, 32'h0); step(); idle();
        total++; if ({flush, upd_valid, err_underflow} !== 3'b001) $display("FAIL uf_flag: got %0h want 1", {flush, upd_valid, err_underflow}); else passed++;
        step(); step();
        total++; if (err_underflow !== 1'b1) $display("FAIL uf_sticky: got %0h want 1", err_underflow); else passed++;
        set_push(32'h500, 1, 32'h600); step();
        set_push(32'h504, 1, 32'h600); step();
        set_push(32'h508, 0, 32'h0);   step(); idle();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        total++; if ({pred_ready, flush, upd_valid, err_underflow, spec_ghr, redirect_pc, upd_index, mispred_cnt} !== {1'b1, 67'b0}) $display("FAIL async_rst: got %0h want 80000000000000000", {pred_ready, flush, upd_valid, err_underflow, spec_ghr, redirect_pc, upd_index, mispred_cnt}); else passed++;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_random();
        logic [68:0] got, want;
        int errs = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            pred_valid  = ($urandom % 3) != 0;
            pred_pc     = 32'($urandom_range(0, 1023)) << 2;
            pred_taken  = $urandom % 2;
            pred_target = 32'($urandom_range(0, 15)) << 4;
            res_valid   = ($urandom % 5) < 2;
            if (q.size() != 0 && ($urandom % 4) != 0) begin
                res_taken  = ($urandom % 5) != 0 ? q[0].t : ~q[0].t;
                res_target = ($urandom % 6) != 0 ? q[0].tg : 32'($urandom_range(0, 15)) << 4;
            end else begin
                res_taken  = $urandom % 2;
                res_target = 32'($urandom_range(0, 15)) << 4;
            end
            step();
            got  = {flush, redirect_pc, upd_valid, upd_index, upd_taken, spec_ghr, mispred_cnt, err_underflow, pred_ready};
            want = {m_flush, m_redir, m_uv, m_ui, m_ut, m_ghr, m_cnt, m_err, 1'(q.size() < 4)};
            total++;
            if (got !== want) begin
                if (errs < 10) $display("FAIL rand_cycle%0d: got %h want %h", i, got, want);
                errs++;
            end else passed++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_correct_taken();
        test_mispredict_not_taken();
        test_mispredict_taken();
        test_full_and_drop();
        test_ghr_index();
        test_underflow_and_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Back end of the branch-prediction loop. Records every control-flow prediction issued at fetch (branch, jal, jalr) in a small in-order queue. When the instruction resolves in EX/MEM, it compares the actual outcome against the recorded prediction. It then produces the pipeline flush and redirect PC, the gshare training update, and speculative global-history repair, and sits between the fetch-side predictor and the EX/MEM stage.

## Interface
- DEPTH, 4, max in-flight predicted control-flow instructions (power of two)
- GHR_W, 8, global history / gshare index width
- PC_W, 32, PC width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pred_valid  in  1  fetch issues a prediction this cycle
- pred_pc  in  PC_W  PC of predicted instruction
- pred_taken  in  1  predicted direction (1 for jal/jalr)
- pred_target  in  PC_W  predicted target
- pred_ready  out  1  queue can accept; fetch stalls when 0
- res_valid  in  1  oldest control-flow instruction resolves this cycle
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual target
- flush  out  1  one-cycle mispredict pulse
- redirect_pc  out  PC_W  correct next PC, valid with flush
- upd_valid  out  1  one-cycle predictor training pulse
- upd_index  out  GHR_W  gshare index to train
- upd_taken  out  1  training direction
- spec_ghr  out  GHR_W  speculative history for fetch-side indexing
- mispred_cnt  out  16  mispredictions since reset, wraps
- err_underflow  out  1  sticky: res_valid seen with empty queue

## Operation
- Queue entry: {pc, taken, target, ghr_snap}; ghr_snap is spec_ghr before this push.
- Push when pred_valid && pred_ready; spec_ghr <= {spec_ghr[GHR_W-2:0], pred_taken}.
- pred_ready = (count != DEPTH), from registered count only; no same-cycle pop bypass; pred_valid while full is ignored.
- Resolve when res_valid && count != 0: pop head.
- mispredict = (res_taken != head.taken) || (res_taken && res_target != head.target).
- upd_valid=1, upd_index = head.pc[GHR_W+1:2] ^ head.ghr_snap, upd_taken = res_taken on every resolve.
- On mispredict:
  - flush=1; redirect_pc = res_taken ? res_target : head.pc + 4 (mod 2^PC_W).
  - Whole queue cleared (count=0).
  - spec_ghr <= {head.ghr_snap[GHR_W-2:0], res_taken}.
  - mispred_cnt += 1.
- Simultaneous push and resolve:
  - Correct resolve: both occur, count unchanged, push wins spec_ghr.
  - Mispredicting resolve: push dropped, spec_ghr takes the repair value.
- res_valid with count==0: no pop, no flush, no update; err_underflow <= 1 until reset.
- Pointers wrap modulo DEPTH; count is a separate DEPTH+1-state counter.

## Timing
- Reset (async on rst_n low, regardless of in-flight work): count=0, pointers=0, spec_ghr=0, flush=0, redirect_pc=0, upd_valid=0, upd_index=0, upd_taken=0, mispred_cnt=0, err_underflow=0, pred_ready=1.
- flush, redirect_pc, upd_*: registered, asserted the cycle after the res_valid edge, for exactly one cycle. redirect_pc and upd_index/upd_taken hold their last values otherwise.
- Queue clear and spec_ghr repair take effect on the same edge that samples the mispredicting res_valid. The next cycle shows count=0 and pred_ready=1.
- Back-to-back resolves each produce their own one-cycle pulses on consecutive cycles.

## Structure
- Shared package bru_pkg:
  - Opcode constants OPC_BRANCH=7'b1100011, OPC_JAL=7'b1101111, OPC_JALR=7'b1100111.
  - Entry typedef bru_entry_t.
  - gshare index function (pc slice XOR history), shared with the fetch-side predictor.
- One sub-module, bru_queue: DEPTH-entry circular FIFO with push, pop, clear, count and full.
- Compare/repair logic and counters live in the top.

## Test plan
- Push pc=0x40 taken=1 target=0x80; resolve taken=1 target=0x80 -> flush=0, upd_valid=1, upd_taken=1, count 0, mispred_cnt 0.
- Push pc=0x100 taken=0; resolve taken=1 target=0x200 -> next cycle flush=1, redirect_pc=0x200, mispred_cnt=1.
- Push pc=0x100 taken=1 target=0x140; resolve taken=0 -> flush=1, redirect_pc=0x104.
- Push 4 entries, 5th pred_valid -> pred_ready=0, 5th ignored. Resolve head mispredicted with simultaneous push -> count 0 next cycle, push dropped, spec_ghr = {snap[6:0], res_taken}.
- spec_ghr=0 after reset; push taken, taken, not-taken -> spec_ghr=8'b00000110. Resolve first entry (pc=0x20) correct -> upd_index = 0x08 ^ 0x00 = 0x08.
- res_valid on empty queue -> no flush, err_underflow=1 until rst_n low. rst_n low mid-flight with 3 entries -> all outputs at reset values immediately.
